mux_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one WIDTH-bit mux path (yMux-family select tree) among NREQ requesters.

---
 rtl/mux_rr_arbiter.sv | 104 ++++++++++
 tb/tb_mux_rr_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared WIDTH-bit mux path.
// A registered grant forwards the owner's beats; bursts end on last, MAX_HOLD beats, or dropped req.
module mux_rr_arbiter #(
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned NREQ     = 4,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ-1:0]               last,
  input  logic [NREQ*WIDTH-1:0]         data_in,
  input  logic                          out_ready,
  output logic [NREQ-1:0]               gnt,
  output logic [$clog2(NREQ)-1:0]       sel,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid
);

  localparam int unsigned SELW = $clog2(NREQ);
  localparam int unsigned HCW  = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic [HCW-1:0]    hold_cnt_q, hold_cnt_d;

  logic              active;
  logic              beat;
  logic              release_c;
  logic              win_found;
  logic [SELW-1:0]   win_idx;
  int unsigned       scan_idx;

  assign active    = (state_q == GRANT);
  assign out_valid = active & req[sel_q];
  assign out_data  = active ? data_in[sel_q*WIDTH +: WIDTH] : '0;
  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign beat      = out_valid & out_ready;

  // last and forced rotation coincide into a single release
  assign release_c = active & ((beat & last[sel_q])
                             | (beat & (hold_cnt_q == HCW'(MAX_HOLD - 1)))
                             | ~req[sel_q]);

  // Priority scan starting just after the last owner
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      scan_idx = 32'(ptr_q) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      if (!win_found && req[SELW'(scan_idx)]) begin
        win_found = 1'b1;
        win_idx   = SELW'(scan_idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    if (!active || release_c) begin
      if (win_found) begin
        state_d    = GRANT;
        gnt_d      = NREQ'(1) << win_idx;
        sel_d      = win_idx;
        ptr_d      = win_idx;
        hold_cnt_d = '0;
      end else begin
        state_d    = IDLE;
        gnt_d      = '0;
        hold_cnt_d = '0;
      end
    end else if (beat) begin
      hold_cnt_d = hold_cnt_q + HCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      ptr_q      <= SELW'(NREQ - 1);
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: reset, latency, rotation, hold limit, stall and drop.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] last;
  logic [7:0] data_in;
  logic       out_ready;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic [1:0] out_data;
  logic       out_valid;

  int vec  = 0;
  int miss = 0;

  mux_rr_arbiter #(.WIDTH(2), .NREQ(4), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last), .data_in(data_in),
    .out_ready(out_ready), .gnt(gnt), .sel(sel), .out_data(out_data),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = 4'b0000;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b0000; last = 4'b0000; out_ready = 1'b0;
    data_in = 8'b00_11_10_01;
    #3;
    vec++; if (gnt !== 4'b0000) begin miss++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    vec++; if (sel !== 2'd0) begin miss++; $display("FAIL reset_sel: got %0d want 0", sel); end
    vec++; if (out_valid !== 1'b0 || out_data !== 2'd0) begin miss++;
      $display("FAIL reset_out: got v=%b d=%0d want v=0 d=0", out_valid, out_data); end
    tick(); tick();
    rst_n = 1'b1; req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
    tick();
    vec++; if (gnt !== 4'b0001 || out_data !== 2'd1) begin miss++;
      $display("FAIL reset_first: got gnt=%b d=%0d want 0001 d=1", gnt, out_data); end
    tick();
    vec++; if (gnt !== 4'b0010) begin miss++; $display("FAIL reset_second: got %b want 0010", gnt); end
    #2; rst_n = 1'b0; #1;
    vec++; if (gnt !== 4'b0000 || out_valid !== 1'b0 || out_data !== 2'd0) begin miss++;
      $display("FAIL reset_async: got gnt=%b v=%b d=%0d want 0000 0 0", gnt, out_valid, out_data); end
    rst_n = 1'b1;
    tick();
    vec++; if (gnt !== 4'b0001) begin miss++; $display("FAIL reset_regrant0: got %b want 0001", gnt); end
    req = 4'b0000; #1;
    vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL reset_dropvalid: got %b want 0", out_valid); end
    tick();
    vec++; if (gnt !== 4'b0000) begin miss++; $display("FAIL reset_idle: got %b want 0000", gnt); end
  endtask

  task automatic test_rotation();
    logic [3:0] eg;
    do_reset();
    data_in = 8'b00_11_10_01;
    req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      eg = 4'b0001 << (i % 4);
      vec++; if (gnt !== eg || sel !== 2'(i % 4) || out_data !== 2'(i + 1) || out_valid !== 1'b1) begin
        miss++;
        $display("FAIL rotation_%0d: got gnt=%b sel=%0d d=%0d v=%b want gnt=%b sel=%0d d=%0d v=1",
                 i, gnt, sel, out_data, out_valid, eg, 2'(i % 4), 2'(i + 1));
      end
    end
    req = 4'b0000;
    tick();
    vec++; if (gnt !== 4'b0000) begin miss++; $display("FAIL rotation_idle: got %b want 0000", gnt); end
  endtask

  task automatic test_hold_limit();
    do_reset();
    req = 4'b0001; last = 4'b0000; out_ready = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      vec++; if (gnt !== 4'b0001) begin miss++; $display("FAIL hold_sole_e%0d: got %b want 0001", e, gnt); end
    end
    req = 4'b0011;
    for (int e = 6; e <= 8; e++) begin
      tick();
      vec++; if (gnt !== 4'b0001) begin miss++; $display("FAIL hold_keep_e%0d: got %b want 0001", e, gnt); end
    end
    tick();
    vec++; if (gnt !== 4'b0010 || sel !== 2'd1) begin miss++;
      $display("FAIL hold_rotate: got gnt=%b sel=%0d want 0010 sel=1", gnt, sel); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    data_in = 8'b00_00_11_00;
    req = 4'b0010; last = 4'b0000; out_ready = 1'b0;
    tick();
    vec++; if (gnt !== 4'b0010) begin miss++; $display("FAIL stall_grant: got %b want 0010", gnt); end
    req = 4'b0011;
    for (int s = 0; s < 3; s++) begin
      tick();
      vec++; if (gnt !== 4'b0010 || sel !== 2'd1 || out_data !== 2'd3 || out_valid !== 1'b1) begin
        miss++;
        $display("FAIL stall_%0d: got gnt=%b sel=%0d d=%0d v=%b want 0010 1 3 1",
                 s, gnt, sel, out_data, out_valid);
      end
    end
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      tick();
      vec++; if (gnt !== 4'b0010) begin miss++; $display("FAIL stall_beat%0d: got %b want 0010", b, gnt); end
    end
    tick();
    vec++; if (gnt !== 4'b0001) begin miss++; $display("FAIL stall_release: got %b want 0001", gnt); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_drop();
    do_reset();
    data_in = 8'b10_01_00_00;
    req = 4'b0100; last = 4'b0000; out_ready = 1'b1;
    tick();
    vec++; if (gnt !== 4'b0100 || out_data !== 2'd1) begin miss++;
      $display("FAIL drop_grant: got gnt=%b d=%0d want 0100 d=1", gnt, out_data); end
    req = 4'b1100;
    tick();
    vec++; if (gnt !== 4'b0100) begin miss++; $display("FAIL drop_nondisturb: got %b want 0100", gnt); end
    req = 4'b1000; #1;
    vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL drop_valid: got %b want 0", out_valid); end
    tick();
    vec++; if (gnt !== 4'b1000 || sel !== 2'd3 || out_valid !== 1'b1 || out_data !== 2'd2) begin miss++;
      $display("FAIL drop_next: got gnt=%b sel=%0d v=%b d=%0d want 1000 3 1 2", gnt, sel, out_valid, out_data); end
    req = 4'b0000;
    tick();
    vec++; if (gnt !== 4'b0000) begin miss++; $display("FAIL drop_idle: got %b want 0000", gnt); end
  endtask

  task automatic test_latency();
    data_in = 8'b00_10_00_00;
    req = 4'b0100; last = 4'b0000; out_ready = 1'b0;
    #1;
    vec++; if (gnt !== 4'b0000 || out_valid !== 1'b0) begin miss++;
      $display("FAIL latency_comb: got gnt=%b v=%b want 0000 0", gnt, out_valid); end
    tick();
    vec++; if (gnt !== 4'b0100 || sel !== 2'd2 || out_valid !== 1'b1 || out_data !== 2'd2) begin miss++;
      $display("FAIL latency_grant: got gnt=%b sel=%0d v=%b d=%0d want 0100 2 1 2", gnt, sel, out_valid, out_data); end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_hold_limit();
    test_stall();
    test_drop();
    test_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
